// File: rtl/pattern_sweep_pkg.sv
// Shared types and defaults for the exhaustive pattern sweep sequencer.
package pattern_sweep_pkg;

  // Default sweep geometry: 5 input bits, 1 response bit, 1-cycle settle and DUT reset
  localparam int DEF_N_WIDTH        = 5;
  localparam int DEF_OUT_WIDTH      = 1;
  localparam int DEF_SETTLE_CYCLES  = 1;
  localparam int DEF_DUT_RST_CYCLES = 1;

  // Width of the shared settle/reset down-counter
  localparam int TIMER_W = 16;

  // Sequencer states
  typedef enum logic [2:0] {
    IDLE,
    DRST,
    SETTLE,
    EMIT,
    DONE
  } sweep_state_t;

  // The timer flags its final cycle when it reaches zero, so a phase of
  // 'cycles' cycles is loaded with cycles-1.
  function automatic logic [TIMER_W-1:0] timerReload(input int cycles);
    return TIMER_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/pattern_sweep_ctrl_timer.sv
// Loadable down-counter with a zero flag, shared by the DUT-reset and
// settle phases of the sweep sequencer.
module sweep_timer
  import pattern_sweep_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         CK,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_loadValue,
  input  logic         i_enable,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load takes priority; otherwise count down while enabled and stop at zero
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadValue;
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pattern_sweep_ctrl.sv
// Sweep sequencer: drives every input pattern of a benchmark DUT in binary
// order, holds each one for a settle time, captures the response and hands
// (pattern, response) records to a logger over valid/ready. Also counts
// records whose response was nonzero.
module pattern_sweep_ctrl
  import pattern_sweep_pkg::*;
#(
  parameter int N_WIDTH        = DEF_N_WIDTH,
  parameter int OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int DUT_RST_CYCLES = DEF_DUT_RST_CYCLES
) (
  input  logic                 CK,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  output logic [0:N_WIDTH-1]   N,
  output logic                 dut_rst,
  input  logic [OUT_WIDTH-1:0] dut_out,
  output logic                 rec_valid,
  input  logic                 rec_ready,
  output logic [0:N_WIDTH-1]   rec_pattern,
  output logic [OUT_WIDTH-1:0] rec_response,
  output logic                 busy,
  output logic                 done,
  output logic [N_WIDTH:0]     hit_count
);

  localparam logic [N_WIDTH-1:0] LAST_PATTERN = '1;

  sweep_state_t r_state;
  sweep_state_t w_nextState;

  logic [N_WIDTH-1:0]   r_pattern;
  logic [OUT_WIDTH-1:0] r_response;
  logic [N_WIDTH:0]     r_hitCount;

  logic               w_timerLoad;
  logic [TIMER_W-1:0] w_timerLoadValue;
  logic               w_timerEnable;
  logic               w_timerZero;

  logic w_clearSweep;
  logic w_advance;
  logic w_capture;
  logic w_handshake;

  sweep_timer #(
    .W (TIMER_W)
  ) u_timer (
    .CK          (CK),
    .reset       (reset),
    .i_load      (w_timerLoad),
    .i_loadValue (w_timerLoadValue),
    .i_enable    (w_timerEnable),
    .o_zero      (w_timerZero)
  );

  // State register
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and datapath control; abort always wins over progress
  always_comb begin
    w_nextState      = r_state;
    w_timerLoad      = 1'b0;
    w_timerLoadValue = '0;
    w_timerEnable    = 1'b0;
    w_clearSweep     = 1'b0;
    w_advance        = 1'b0;
    w_capture        = 1'b0;
    w_handshake      = (r_state == EMIT) && rec_ready;

    unique case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_nextState      = DRST;
          w_clearSweep     = 1'b1;
          w_timerLoad      = 1'b1;
          w_timerLoadValue = timerReload(DUT_RST_CYCLES);
        end
      end

      DRST: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_timerZero) begin
          w_nextState      = SETTLE;
          w_timerLoad      = 1'b1;
          w_timerLoadValue = timerReload(SETTLE_CYCLES);
        end else begin
          w_timerEnable = 1'b1;
        end
      end

      SETTLE: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_timerZero) begin
          w_nextState = EMIT;
          w_capture   = 1'b1;
        end else begin
          w_timerEnable = 1'b1;
        end
      end

      EMIT: begin
        if (abort) begin
          w_nextState = IDLE;
        end else if (w_handshake) begin
          if (r_pattern == LAST_PATTERN) begin
            w_nextState = DONE;
          end else begin
            w_nextState      = SETTLE;
            w_advance        = 1'b1;
            w_timerLoad      = 1'b1;
            w_timerLoadValue = timerReload(SETTLE_CYCLES);
          end
        end
      end

      DONE: begin
        w_nextState = IDLE;
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Pattern, captured response and hit counter; a handshake that lands in
  // the abort cycle still counts as a transferred record
  always_ff @(posedge CK or negedge reset) begin
    if (!reset) begin
      r_pattern  <= '0;
      r_response <= '0;
      r_hitCount <= '0;
    end else begin
      if (w_clearSweep) begin
        r_pattern  <= '0;
        r_hitCount <= '0;
      end else begin
        if (w_advance) begin
          r_pattern <= r_pattern + N_WIDTH'(1);
        end
        if (w_handshake && (r_response != '0)) begin
          r_hitCount <= r_hitCount + (N_WIDTH + 1)'(1);
        end
      end
      if (w_capture) begin
        r_response <= dut_out;
      end
    end
  end

  // Status strobes decode straight from the state register, so they change
  // only on clock edges; N and rec_pattern both mirror the pattern register
  // with N[0] as the MSB
  assign N            = r_pattern;
  assign rec_pattern  = r_pattern;
  assign rec_response = r_response;
  assign hit_count    = r_hitCount;
  assign busy         = (r_state != IDLE);
  assign done         = (r_state == DONE);
  assign dut_rst      = (r_state == DRST);
  assign rec_valid    = (r_state == EMIT);

endmodule

// File: doc/pattern_sweep_ctrl.md
# pattern_sweep_ctrl

Sequencer that exhaustively drives a combinational/sequential benchmark DUT through every input pattern in binary order, waits a programmable settle time per pattern, captures the DUT response and hands each (pattern, response) record to a downstream logger over a valid/ready handshake. It sits between the benchmark DUT and the capture/logging path of the trojan-detection data-generation flow. It also counts nonzero responses, used as a trigger-activity summary.

## Interface
- N_WIDTH, 5, number of DUT input bits; 2**N_WIDTH patterns per sweep
- OUT_WIDTH, 1, DUT response width
- SETTLE_CYCLES, 1, cycles each pattern is held before capture (>=1)
- DUT_RST_CYCLES, 1, cycles dut_rst is held at sweep start (>=1)

- CK  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  begin sweep; sampled only in IDLE
- abort  in  1  terminate sweep; return to IDLE
- N  out  [0:N_WIDTH-1]  pattern to DUT; N[0] is MSB
- dut_rst  out  1  active-high reset to DUT
- dut_out  in  OUT_WIDTH  DUT response
- rec_valid  out  1  record available
- rec_ready  in  1  logger accepts record
- rec_pattern  out  [0:N_WIDTH-1]  pattern of the record
- rec_response  out  OUT_WIDTH  captured response
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when sweep completes
- hit_count  out  N_WIDTH+1  records with nonzero response in current/last sweep

## Operation
- States: IDLE, DRST, SETTLE, EMIT, DONE.
- IDLE: start=1 -> DRST; pattern<=0, hit_count<=0, timer<=DUT_RST_CYCLES.
- DRST: dut_rst=1; after DUT_RST_CYCLES cycles -> SETTLE, timer<=SETTLE_CYCLES.
- SETTLE: N holds pattern; timer decrements; on last SETTLE cycle edge rec_response<=dut_out -> EMIT.
- EMIT: rec_valid=1, rec_pattern=pattern, rec_response stable until handshake. On rec_valid&rec_ready: hit_count += (response!=0); if pattern==all-ones -> DONE, else pattern+1 -> SETTLE (timer reloaded).
- DONE: done=1 for one cycle -> IDLE. hit_count holds until next start.
- N always equals pattern register (no glitch between SETTLE and EMIT); N stays at last pattern after DONE until next start.
- start while busy: ignored. start and abort same cycle in IDLE: abort wins, stay IDLE.
- abort in any non-IDLE state: next state IDLE, rec_valid and dut_rst drop next cycle, done not pulsed, hit_count frozen. Handshake completing in the abort cycle counts as transferred (hit_count updated).
- rec_valid never drops without handshake except on abort or reset.
- Pattern increment wraps never occurs: all-ones terminates the sweep.

## Timing
- Reset values: N=0, dut_rst=0, rec_valid=0, rec_pattern=0, rec_response=0, busy=0, done=0, hit_count=0, state IDLE. Reset mid-sweep takes effect asynchronously; no partial record is emitted after release.
- start at edge t -> busy and dut_rst high from t+1.
- First rec_valid at t+1+DUT_RST_CYCLES+SETTLE_CYCLES.
- Per pattern with rec_ready tied high: SETTLE_CYCLES+1 cycles. Each low rec_ready cycle in EMIT adds one cycle.
- Full sweep, rec_ready=1: DUT_RST_CYCLES + 2**N_WIDTH*(SETTLE_CYCLES+1) + 1 cycles of busy (defaults: 66).
- dut_out is sampled exactly SETTLE_CYCLES edges after N changes.

## Structure
- Package pattern_sweep_pkg: state enum typedef (IDLE, DRST, SETTLE, EMIT, DONE), default parameter constants.
- One sub-module: sweep_timer — loadable down-counter with zero flag, shared by DRST and SETTLE.

## Test plan
- Defaults, rec_ready=1, dut_out=N[4] -> 32 records, patterns 0..31 in order, response = LSB, hit_count=16, done pulse at cycle 66 after start.
- rec_ready low 3 cycles on pattern 5 -> rec_valid and rec_pattern=5 held stable 4 cycles, N unchanged, pattern 6 follows.
- SETTLE_CYCLES=3, DUT with 2-cycle output delay -> captured response matches delayed value for every pattern.
- abort during EMIT of pattern 10 with rec_ready=0 -> rec_valid low next cycle, no done, hit_count frozen, busy=0; new start restarts at pattern 0 with hit_count=0.
- reset asserted mid-SETTLE -> all outputs immediately at reset values; start after release gives full normal sweep.
- start pulsed while busy and start+abort in IDLE -> both ignored, no state change.
